// File: rtl/tensor_product_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tensor_product_arbiter
//
// Shares one tensor product unit between two requesters. Requests are
// arbitrated round-robin. The winner's a/b operands are latched and driven to
// the unit, and a one-cycle start pulse launches the unit. The arbiter then
// waits for valid, error or a timeout. The outcome comes back to the winner as
// a one-cycle done or err pulse. The registered product stays on `result`
// until the next successful operation.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req0/req1         requester wants one product
//   a0/a1, b0/b1      per-requester operands, sampled when the grant is issued
//   grant0/grant1     requester currently owns the product unit
//   done0/done1       one-cycle pulse, result valid for that requester
//   err0/err1         one-cycle pulse, unit error or timeout
//   result            last good product, held until the next done
//   busy              an operation is in flight (not IDLE)
//   tp_start          one-cycle launch pulse to the unit
//   tp_a/tp_b         latched operands driven to the unit
//   tp_result         product from the unit
//   tp_valid/tp_error unit result valid / unit fault (only honoured in WAIT)
// -----------------------------------------------------------------------------
module tensor_product_arbiter #(
  parameter int A_VECTOR_LEN      = 5,
  parameter int B_VECTOR_LEN      = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 12,
  parameter int TIMEOUT           = 255
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  req0,
  input  logic                                                  req1,
  input  logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0]                  a0,
  input  logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0]                  a1,
  input  logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0]                  b0,
  input  logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0]                  b1,
  output logic                                                  grant0,
  output logic                                                  grant1,
  output logic                                                  done0,
  output logic                                                  done1,
  output logic                                                  err0,
  output logic                                                  err1,
  output logic [A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                                  busy,
  output logic                                                  tp_start,
  output logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0]                  tp_a,
  output logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0]                  tp_b,
  input  logic [A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH-1:0] tp_result,
  input  logic                                                  tp_valid,
  input  logic                                                  tp_error
);

  localparam int AW = A_VECTOR_LEN * A_CELL_WIDTH;
  localparam int BW = B_VECTOR_LEN * B_CELL_WIDTH;
  localparam int RW = A_VECTOR_LEN * B_VECTOR_LEN * RESULT_CELL_WIDTH;
  // Counter wide enough to hold TIMEOUT itself; never narrower than one bit.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_reg;
  logic            last_reg;      // index of the most recently served requester
  logic            owner_reg;     // index of the requester being served now
  logic [CW-1:0]   cnt_reg;
  logic [1:0]      grant_reg;
  logic [1:0]      done_reg;
  logic [1:0]      err_reg;
  logic            tp_start_reg;
  logic [AW-1:0]   tp_a_reg;
  logic [BW-1:0]   tp_b_reg;
  logic [RW-1:0]   result_reg;

  logic [1:0]      req_vec;
  logic            pick;          // winner index if arbitration happens this cycle
  logic [AW-1:0]   a_sel;
  logic [BW-1:0]   b_sel;

  assign req_vec = {req1, req0};

  // Round-robin: on a tie the requester that was not served last wins; a
  // lone requester always wins. With no request, pick is don't-care.
  always_comb begin
    pick = 1'b0;
    if (req_vec == 2'b11) begin
      pick = ~last_reg;
    end else if (req_vec[1]) begin
      pick = 1'b1;
    end
  end

  // Per-cell operand steering towards the latch, one mux per cell.
  genvar gi;
  generate
    for (gi = 0; gi < A_VECTOR_LEN; gi++) begin : g_a_cell
      assign a_sel[gi*A_CELL_WIDTH +: A_CELL_WIDTH] =
        pick ? a1[gi*A_CELL_WIDTH +: A_CELL_WIDTH] : a0[gi*A_CELL_WIDTH +: A_CELL_WIDTH];
    end
    for (gi = 0; gi < B_VECTOR_LEN; gi++) begin : g_b_cell
      assign b_sel[gi*B_CELL_WIDTH +: B_CELL_WIDTH] =
        pick ? b1[gi*B_CELL_WIDTH +: B_CELL_WIDTH] : b0[gi*B_CELL_WIDTH +: B_CELL_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      owner_reg    <= 1'b0;
      cnt_reg      <= '0;
      grant_reg    <= '0;
      done_reg     <= '0;
      err_reg      <= '0;
      tp_start_reg <= 1'b0;
      tp_a_reg     <= '0;
      tp_b_reg     <= '0;
      result_reg   <= '0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      done_reg     <= '0;
      err_reg      <= '0;
      tp_start_reg <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            owner_reg    <= pick;
            grant_reg    <= pick ? 2'b10 : 2'b01;
            tp_a_reg     <= a_sel;
            tp_b_reg     <= b_sel;
            // Raised here so the start pulse occupies the LAUNCH cycle.
            tp_start_reg <= 1'b1;
            state_reg    <= LAUNCH;
          end
        end

        LAUNCH: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end

        WAIT: begin
          // Error beats valid, valid beats the timeout.
          if (tp_error) begin
            err_reg[owner_reg] <= 1'b1;
            grant_reg          <= '0;
            last_reg           <= owner_reg;
            state_reg          <= IDLE;
          end else if (tp_valid) begin
            result_reg          <= tp_result;
            done_reg[owner_reg] <= 1'b1;
            state_reg           <= DONE;
          end else if (cnt_reg == TIMEOUT_CNT) begin
            err_reg[owner_reg] <= 1'b1;
            grant_reg          <= '0;
            last_reg           <= owner_reg;
            state_reg          <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        DONE: begin
          grant_reg <= '0;
          last_reg  <= owner_reg;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign grant0   = grant_reg[0];
  assign grant1   = grant_reg[1];
  assign done0    = done_reg[0];
  assign done1    = done_reg[1];
  assign err0     = err_reg[0];
  assign err1     = err_reg[1];
  assign tp_start = tp_start_reg;
  assign tp_a     = tp_a_reg;
  assign tp_b     = tp_b_reg;
  assign result   = result_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: doc/tensor_product_arbiter.md
TENSOR_PRODUCT_ARBITER -- requirements
Module: tensor_product_arbiter

Interface
REQ-001 SHALL have parameters: A_VECTOR_LEN, default 5, cells in vector a; B_VECTOR_LEN, default 5, cells in vector b; A_CELL_WIDTH, default 8, bits per a cell; B_CELL_WIDTH, default 8, bits per b cell; RESULT_CELL_WIDTH, default 12, bits per result cell; TIMEOUT, default 255, max cycles waited for the product.
REQ-002 SHALL have ports, clock and reset first. RW = A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH.
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  synchronous, active-high reset
  req0, req1  in  1 each  requester 0/1 wants one product
  a0, a1  in  A_VECTOR_LEN*A_CELL_WIDTH  a operand per requester
  b0, b1  in  B_VECTOR_LEN*B_CELL_WIDTH  b operand per requester
  grant0, grant1  out  1 each  requester owns the shared tensor product unit
  done0, done1  out  1 each  one-cycle pulse, result is valid for that requester
  err0, err1  out  1 each  one-cycle pulse, operation failed
  result  out  RW  registered product, held until the next done
  busy  out  1  FSM not in IDLE
  tp_start  out  1  one-cycle start pulse to the shared product unit
  tp_a, tp_b  out  operand widths  latched operands driven to the unit
  tp_result  in  RW  product from the unit
  tp_valid  in  1  unit result valid
  tp_error  in  1  unit overflow/fault

Function
REQ-003 SHALL implement FSM states IDLE, LAUNCH, WAIT, DONE.
REQ-004 IDLE: if any req is high, SHALL pick a winner, latch its a/b into tp_a/tp_b, set its grant, and go to LAUNCH on the next edge.
REQ-005 Arbitration SHALL be round-robin: a 1-bit last pointer records the last winner; on simultaneous req0/req1 the non-last requester wins; a sole requester always wins. Pointer reset value is 1, so requester 0 wins the first tie.
REQ-006 LAUNCH SHALL assert tp_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-007 WAIT SHALL increment the timeout counter each cycle. It counts up to ceil(log2(TIMEOUT+1)) bits.
REQ-008 WAIT exits, with priority tp_error > tp_valid > timeout:
  - tp_error: pulse err of the winner, go to IDLE.
  - tp_valid: register tp_result into result, go to DONE.
  - counter reaches TIMEOUT: pulse err, go to IDLE.
REQ-009 DONE SHALL pulse done of the winner for one cycle, clear grant, update last, and go to IDLE.
REQ-010 On an error or timeout exit, grant SHALL clear, last SHALL update, and result SHALL keep its previous value.
REQ-011 tp_valid and tp_error outside WAIT SHALL be ignored.
REQ-012 Latency: req sampled in IDLE at edge N gives grant high after N and tp_start high during cycle N+1. tp_valid sampled at edge M gives done high during cycle M+1, and IDLE at M+2. A still-asserted req is re-arbitrated from IDLE, with no bubble beyond the IDLE cycle.
REQ-013 A req deasserted while granted SHALL NOT abort the operation; done/err still pulse. Requesters hold operands only until grant rises, because the operands are latched.
REQ-014 At most one grant, and at most one of done0/done1/err0/err1, SHALL be high in any cycle.
REQ-015 busy SHALL be high in LAUNCH, WAIT and DONE.

Reset
REQ-016 rst high at an edge SHALL force: IDLE; all grant/done/err/tp_start low; busy low; last=1; counter=0; tp_a, tp_b and result zero. This holds mid-operation too; a tp_valid arriving in the same cycle as rst is discarded.
REQ-017 No output pulse SHALL occur in the cycle after rst deasserts unless REQ-004 applies.

Verification
REQ-018 Single request: req0 with a0={-50,40,30,20,10} and b0={1,2,-3,4,5}; a model returns tp_valid 6 cycles after tp_start. Required: grant0, exactly one tp_start, done0 one cycle after tp_valid, result equal to tp_result, done1 never.
REQ-019 Tie: req0 and req1 high together from reset. Required grant order 0,1,0,1 over four operations, with tp_a alternating between a0 and a1.
REQ-020 Error: the model asserts tp_error and tp_valid in the same cycle. Required: err0 pulse, no done0, result unchanged, back to IDLE next cycle.
REQ-021 Timeout with TIMEOUT=10 and the model never valid. Required: err pulse during the cycle after counter=10, grant cleared, the other requester then served.
REQ-022 Reset mid-WAIT: rst asserted 3 cycles after tp_start. Required: all outputs at reset values next cycle, and a later tp_valid is ignored.
REQ-023 Req dropped: req1 falls the cycle after grant1. Required: the operation completes and done1 still pulses.
